// File: rtl/nat_arith_unit.sv
// Registered natural-number arithmetic unit: 2N-bit add with carry, NxN multiply-add,
// and two-digit BCD-to-binary conversion, one cycle of latency, no backpressure.
module nat_arith_unit #(
  parameter int unsigned N = 4
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [2*N-1:0]   x,
  input  logic [2*N-1:0]   y,
  input  logic [N-1:0]     c,
  input  logic             c_in,
  output logic             out_valid,
  output logic [2*N-1:0]   r,
  output logic             c_out,
  output logic             ow,
  output logic             err
);

  localparam int unsigned W = 2 * N;

  localparam logic [1:0] OP_ADD     = 2'd0;
  localparam logic [1:0] OP_MULADD  = 2'd1;
  localparam logic [1:0] OP_BCD2BIN = 2'd2;

  logic         out_valid_d, out_valid_q;
  logic [W-1:0] r_d, r_q;
  logic         c_out_d, c_out_q;
  logic         ow_d, ow_q;
  logic         err_d, err_q;

  logic [W:0]   add_sum;
  logic [W-1:0] mul_sum;
  logic [N-1:0] tens;
  logic [N-1:0] units;
  logic [W-1:0] bcd_sum;
  logic         bcd_bad;

  // Datapaths for every op are evaluated in parallel; the select only picks one.
  always_comb begin
    add_sum = {1'b0, x} + {1'b0, y} + (W+1)'(c_in);
    mul_sum = W'(x[N-1:0]) * W'(y[N-1:0]) + W'(c);
    tens    = x[W-1:N];
    units   = x[N-1:0];
    bcd_sum = (W'(tens) << 3) + (W'(tens) << 1) + W'(units);
    bcd_bad = (tens > N'(9)) || (units > N'(9));
  end

  // Result registers hold when no request is accepted.
  always_comb begin
    out_valid_d = in_valid;
    r_d         = r_q;
    c_out_d     = c_out_q;
    ow_d        = ow_q;
    err_d       = err_q;
    if (in_valid) begin
      r_d     = '0;
      c_out_d = 1'b0;
      ow_d    = 1'b0;
      err_d   = 1'b0;
      case (op)
        OP_ADD: begin
          r_d     = add_sum[W-1:0];
          c_out_d = add_sum[W];
          ow_d    = (x[W-1] == y[W-1]) && (add_sum[W-1] != x[W-1]);
        end
        OP_MULADD: begin
          r_d = mul_sum;
        end
        OP_BCD2BIN: begin
          r_d   = bcd_sum;
          err_d = bcd_bad;
        end
        default: begin
          err_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      out_valid_q <= 1'b0;
      r_q         <= '0;
      c_out_q     <= 1'b0;
      ow_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      r_q         <= r_d;
      c_out_q     <= c_out_d;
      ow_q        <= ow_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign r         = r_q;
  assign c_out     = c_out_q;
  assign ow        = ow_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nat_arith_unit.sv
// Scoreboard bench for nat_arith_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever out_valid is high.
module tb_nat_arith_unit;

  localparam int unsigned N = 4;
  localparam int unsigned W = 2 * N;

  logic         clock;
  logic         reset_;
  logic         in_valid;
  logic [1:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [N-1:0] c;
  logic         c_in;
  logic         out_valid;
  logic [W-1:0] r;
  logic         c_out;
  logic         ow;
  logic         err;

  typedef struct packed {
    logic [W-1:0] r;
    logic         co;
    logic         ow;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   last_run = 0;

  nat_arith_unit #(.N(N)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .in_valid  (in_valid),
    .op        (op),
    .x         (x),
    .y         (y),
    .c         (c),
    .c_in      (c_in),
    .out_valid (out_valid),
    .r         (r),
    .c_out     (c_out),
    .ow        (ow),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare each presented result against the oldest expected entry.
  always @(negedge clock) begin
    exp_t e;
    exp_t a;
    if (reset_ && out_valid) begin
      run_len = run_len + 1;
      a = '{r: r, co: c_out, ow: ow, err: err};
      checks = checks + 1;
      if (sb.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_valid: got r=%0h c_out=%0b ow=%0b err=%0b with nothing expected",
                 r, c_out, ow, err);
      end else begin
        e = sb.pop_front();
        if (a !== e) begin
          errors = errors + 1;
          $display("FAIL result: got r=%0h c_out=%0b ow=%0b err=%0b, want r=%0h c_out=%0b ow=%0b err=%0b",
                   r, c_out, ow, err, e.r, e.co, e.ow, e.err);
        end
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks = checks + 1;
    if (got != want) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [N-1:0] cv, input logic ci);
    @(posedge clock);
    #1;
    in_valid = 1'b1;
    op       = o;
    x        = xv;
    y        = yv;
    c        = cv;
    c_in     = ci;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic [N-1:0] cv, input logic ci,
                       input logic [W-1:0] er, input logic eco, input logic eow, input logic eerr);
    drive(o, xv, yv, cv, ci);
    sb.push_back('{r: er, co: eco, ow: eow, err: eerr});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      op       = 2'd0;
      x        = 8'hEE;
      y        = 8'hDD;
      c        = 4'hC;
      c_in     = 1'b1;
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_   = 1'b0;
    in_valid = 1'b0;
    op       = 2'd0;
    x        = '0;
    y        = '0;
    c        = '0;
    c_in     = 1'b0;
    #3;
    check("reset_state", {out_valid, r, c_out, ow, err}, 0);
    #20;
    reset_ = 1'b1;
    idle(2);

    // ADD
    issue(2'd0, 8'h7F, 8'h01, 4'h0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    issue(2'd0, 8'hFF, 8'h01, 4'h0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    issue(2'd0, 8'h80, 8'h80, 4'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    // MULADD right after a carry: flags must clear
    issue(2'd1, 8'h0F, 8'h0F, 4'hF, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    issue(2'd1, 8'h3A, 8'h5B, 4'h0, 1'b0, 8'd110, 1'b0, 1'b0, 1'b0);
    // BCD2BIN
    issue(2'd2, 8'h99, 8'hFF, 4'hF, 1'b1, 8'd99, 1'b0, 1'b0, 1'b0);
    issue(2'd2, 8'h42, 8'h00, 4'h0, 1'b0, 8'd42, 1'b0, 1'b0, 1'b0);
    issue(2'd2, 8'hA3, 8'h00, 4'h0, 1'b0, 8'd103, 1'b0, 1'b0, 1'b1);
    issue(2'd2, 8'h9F, 8'h00, 4'h0, 1'b0, 8'd105, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Throughput: three back-to-back requests
    issue(2'd0, 8'h01, 8'h02, 4'h0, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0);
    issue(2'd1, 8'h03, 8'h04, 4'h1, 1'b0, 8'd13, 1'b0, 1'b0, 1'b0);
    issue(2'd2, 8'h07, 8'h00, 4'h0, 1'b0, 8'd7, 1'b0, 1'b0, 1'b0);
    idle(1);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("tp_valid_low", int'(out_valid), 0);
    check("tp_r_held", int'(r), 7);
    check("tp_run_length", last_run, 3);

    // Reserved op pulses once with err
    issue(2'd3, 8'h55, 8'h66, 4'h7, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
    idle(1);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("rsv_run_length", last_run, 1);
    check("rsv_err_held", int'(err), 1);

    // Reset with a request pending mid-cycle
    issue(2'd0, 8'h10, 8'h20, 4'h0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    drive(2'd0, 8'hF0, 8'hF0, 4'h0, 1'b1);
    #5;
    check("pre_reset_r", int'(r), 8'h30);
    reset_ = 1'b0;
    #1;
    check("async_reset", {out_valid, r, c_out, ow, err}, 0);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    check("reset_held", {out_valid, r, c_out, ow, err}, 0);
    #2;
    reset_ = 1'b1;
    idle(4);
    check("no_valid_after_reset", int'(out_valid), 0);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
